regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port register file with a per-register pending-write scoreboard, replacing the single-write, two-read, falling-edge-read register file in the pipeline's decode/writeback path. It provides RD_PORTS synchronous read ports and WR_PORTS write ports with defined same-register write priority. Decode sets busy bits for destination registers at issue and writeback clears them, so the hazard unit gets data and a "still pending" flag from the same read.

## Interface
- REG_COUNT, 32, number of registers; register 0 is hard-wired zero.
- REG_W, 32, register width in bits.
- REG_IDX_W, $clog2(REG_COUNT), register index width.
- RD_PORTS, 2, number of read ports (1..4).
- WR_PORTS, 2, number of write ports (1..2).

- clk  input  1  clock; all state changes on the rising edge.
- areset  input  1  reset, asynchronous and active-high; clears all state.
- rd_reg  input  RD_PORTS*REG_IDX_W  read indices; port p uses bits [p*REG_IDX_W +: REG_IDX_W].
- rd_data  output  RD_PORTS*REG_W  registered read data, port p at [p*REG_W +: REG_W].
- rd_busy  output  RD_PORTS  registered busy flag of the register read on port p.
- wr_en  input  WR_PORTS  per-port write enable.
- wr_reg  input  WR_PORTS*REG_IDX_W  per-port write index.
- wr_data  input  WR_PORTS*REG_W  per-port write data.
- alloc_en  input  1  mark alloc_reg as pending (destination issued).
- alloc_reg  input  REG_IDX_W  register to mark pending.
- busy_vec  output  REG_COUNT  current scoreboard, bit i = register i pending; bit 0 always 0.

## Operation
- Reset (areset high, any time, mid-operation included): all registers 0, all busy bits 0, rd_data 0, rd_busy 0, busy_vec 0. Outputs hold 0 while areset is high; normal operation resumes on the first rising edge after deassertion.
- Write: on the rising edge, each port with wr_en=1 and wr_reg!=0 writes wr_data. Writes to register 0 are ignored.
- Write conflict: when two ports write the same register in one cycle, the higher-numbered port wins.
- Writeback clears busy: every enabled write with wr_reg!=0 clears busy[wr_reg] on the same edge.
- Alloc: alloc_en=1 and alloc_reg!=0 sets busy[alloc_reg]. Alloc of register 0 is ignored.
- Alloc and write to the same register in one cycle: the set wins, so busy stays 1. The older result is written, and the newer producer still owns the register.
- Re-alloc of an already-busy register: no change; it stays busy.
- Read: each port samples rd_reg on the rising edge. rd_data and rd_busy for that port update on the same edge.
- Read of register 0 always returns data 0 and busy 0.
- Read ports are independent. Any number may address the same register.

## Timing
- Write latency: wr_data is stored at edge k.
- Read latency: 1 cycle. rd_reg presented before edge k gives rd_data/rd_busy valid after edge k, stable until edge k+1.
- Same-edge write and read of one register: the result depends on REGFILE_BYPASS_EN (see Configuration).
- busy_vec is the registered scoreboard. It reflects alloc/clear from edge k after edge k.
- No combinational path from any input to any output.

## Configuration
- REGFILE_BYPASS_EN defined (write-first):
  - A read sampled at edge k of a register written at edge k returns the new wr_data, after the conflict priority is applied.
  - rd_busy returns the post-edge busy value, so a writeback clears the flag in the same read.
- REGFILE_BYPASS_EN undefined (read-first):
  - The read returns the pre-edge register value, and rd_busy returns the pre-edge busy value.
  - So a consumer reading in the writeback cycle sees busy=1 and stalls one more cycle.
- Scoreboard set/clear behaviour and busy_vec are identical in both builds.

## Test plan
- Reset: preload r5=0x1234, assert areset between clock edges -> rd_data, rd_busy, busy_vec go 0 immediately. After release, a read of r5 returns 0x00000000.
- Register 0: write 0xDEADBEEF to r0 on both ports and alloc r0 -> the read of r0 returns 0 with busy 0, and busy_vec[0]=0.
- Write conflict: port0 writes r3=0x11, port1 writes r3=0x22 on the same edge -> the next read of r3 returns 0x22.
- Scoreboard: alloc r7 at edge 1 -> busy_vec[7]=1 after edge 1. Write r7=0x55 at edge 4 -> busy_vec[7]=0 after edge 4. Alloc r7 plus write r7 on the same edge -> busy_vec[7] stays 1 and the data is updated.
- Bypass: r9=0x1 and busy, then write r9=0x2 while reading r9 on both ports at the same edge:
  - with REGFILE_BYPASS_EN -> rd_data=0x2, rd_busy=0;
  - without -> rd_data=0x1, rd_busy=1, then 0x2/0 one cycle later.
- Port independence: RD_PORTS=4 reading r1, r2, r1, r0 with r1=0xA and r2=0xB -> 0xA, 0xB, 0xA, 0x0 after one cycle.

Source files
------------

// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
// Multi-port register file with a per-register pending-write scoreboard.
// Decode marks a destination register busy when it issues (alloc) and
// writeback clears the flag when the result lands, so a single read gives
// the hazard unit both the operand and its "still pending" status.
//
// Parameters:
//   REG_COUNT  number of registers (register 0 is hard-wired zero)
//   REG_W      register width in bits
//   REG_IDX_W  register index width
//   RD_PORTS   number of synchronous read ports (1..4)
//   WR_PORTS   number of write ports (1..2), higher-numbered port wins
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   areset     asynchronous active-high reset, clears all state and outputs
//   rd_reg     read indices, port p at [p*REG_IDX_W +: REG_IDX_W]
//   rd_data    registered read data, port p at [p*REG_W +: REG_W]
//   rd_busy    registered busy flag of the register read on port p
//   wr_en      per-port write enable
//   wr_reg     per-port write index
//   wr_data    per-port write data
//   alloc_en   mark alloc_reg as pending
//   alloc_reg  register to mark pending
//   busy_vec   registered scoreboard, bit i = register i pending
//
// Build option:
//   REGFILE_BYPASS_EN  defined   -> write-first reads (same-edge write data and
//                                   post-edge busy are returned)
//                      undefined -> read-first reads (pre-edge data and busy)
// -----------------------------------------------------------------------------
module regfile_mp #(
   parameter int REG_COUNT = 32,
   parameter int REG_W     = 32,
   parameter int REG_IDX_W = $clog2(REG_COUNT),
   parameter int RD_PORTS  = 2,
   parameter int WR_PORTS  = 2
) (
   input  logic                            clk,
   input  logic                            areset,
   input  logic [RD_PORTS*REG_IDX_W-1:0]   rd_reg,
   output logic [RD_PORTS*REG_W-1:0]       rd_data,
   output logic [RD_PORTS-1:0]             rd_busy,
   input  logic [WR_PORTS-1:0]             wr_en,
   input  logic [WR_PORTS*REG_IDX_W-1:0]   wr_reg,
   input  logic [WR_PORTS*REG_W-1:0]       wr_data,
   input  logic                            alloc_en,
   input  logic [REG_IDX_W-1:0]            alloc_reg,
   output logic [REG_COUNT-1:0]            busy_vec
);

   logic [REG_W-1:0]     regs [REG_COUNT];
   logic [REG_COUNT-1:0] busy;
   logic [REG_COUNT-1:0] busy_next;
   logic [REG_W-1:0]     rd_data_next [RD_PORTS];
   logic [RD_PORTS-1:0]  rd_busy_next;

   // Scoreboard update: writebacks clear first, then the alloc sets, so an
   // alloc and a writeback to the same register leave it busy (the newer
   // producer still owns the register).
   always_comb begin
      busy_next = busy;
      for (int w = 0; w < WR_PORTS; w++) begin
         if (wr_en[w] && (wr_reg[w*REG_IDX_W +: REG_IDX_W] != '0))
            busy_next[wr_reg[w*REG_IDX_W +: REG_IDX_W]] = 1'b0;
      end
      if (alloc_en && (alloc_reg != '0))
         busy_next[alloc_reg] = 1'b1;
      busy_next[0] = 1'b0;
   end

   // Read data selection. In the write-first build the write ports are
   // scanned in ascending order so the highest-numbered matching port
   // overrides, mirroring the storage priority.
   always_comb begin
      for (int p = 0; p < RD_PORTS; p++) begin
         rd_data_next[p] = regs[rd_reg[p*REG_IDX_W +: REG_IDX_W]];
`ifdef REGFILE_BYPASS_EN
         rd_busy_next[p] = busy_next[rd_reg[p*REG_IDX_W +: REG_IDX_W]];
         for (int w = 0; w < WR_PORTS; w++) begin
            if (wr_en[w] &&
                (wr_reg[w*REG_IDX_W +: REG_IDX_W] == rd_reg[p*REG_IDX_W +: REG_IDX_W]))
               rd_data_next[p] = wr_data[w*REG_W +: REG_W];
         end
`else
         rd_busy_next[p] = busy[rd_reg[p*REG_IDX_W +: REG_IDX_W]];
`endif
         if (rd_reg[p*REG_IDX_W +: REG_IDX_W] == '0) begin
            rd_data_next[p] = '0;
            rd_busy_next[p] = 1'b0;
         end
      end
   end

   // Register storage. Later loop iterations win for the same index, which
   // gives the higher-numbered write port priority. Register 0 is never
   // written, so it stays at its reset value of zero.
   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         for (int i = 0; i < REG_COUNT; i++)
            regs[i] <= '0;
      end else begin
         for (int w = 0; w < WR_PORTS; w++) begin
            if (wr_en[w] && (wr_reg[w*REG_IDX_W +: REG_IDX_W] != '0))
               regs[wr_reg[w*REG_IDX_W +: REG_IDX_W]] <= wr_data[w*REG_W +: REG_W];
         end
      end
   end

   // Scoreboard and registered read outputs.
   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         busy    <= '0;
         rd_data <= '0;
         rd_busy <= '0;
      end else begin
         busy <= busy_next;
         for (int p = 0; p < RD_PORTS; p++)
            rd_data[p*REG_W +: REG_W] <= rd_data_next[p];
         rd_busy <= rd_busy_next;
      end
   end

   assign busy_vec = busy;

endmodule

// File: tb/tb_regfile_mp.sv
// -----------------------------------------------------------------------------
// tb_regfile_mp
// Directed, table-driven bench for regfile_mp with four read ports and two
// write ports. Each vector is driven on the falling edge, and the outputs are
// compared 1 time unit after the following rising edge.
// -----------------------------------------------------------------------------
module tb_regfile_mp;

   localparam int RP = 4;
   localparam int WP = 2;

   logic          clk;
   logic          areset;
   logic [19:0]   rd_reg;
   logic [127:0]  rd_data;
   logic [3:0]    rd_busy;
   logic [1:0]    wr_en;
   logic [9:0]    wr_reg;
   logic [63:0]   wr_data;
   logic          alloc_en;
   logic [4:0]    alloc_reg;
   logic [31:0]   busy_vec;

   int checks;
   int errors;

   typedef struct {
      string        name;
      logic [1:0]   we;
      logic [9:0]   wreg;
      logic [63:0]  wdata;
      logic         ae;
      logic [4:0]   areg;
      logic [19:0]  rreg;
      logic [127:0] exp_data;
      logic [3:0]   exp_busy;
      logic [31:0]  exp_bv;
   } vec_t;

   vec_t vecs [13];

   regfile_mp #(
      .REG_COUNT (32),
      .REG_W     (32),
      .RD_PORTS  (RP),
      .WR_PORTS  (WP)
   ) dut (
      .clk       (clk),
      .areset    (areset),
      .rd_reg    (rd_reg),
      .rd_data   (rd_data),
      .rd_busy   (rd_busy),
      .wr_en     (wr_en),
      .wr_reg    (wr_reg),
      .wr_data   (wr_data),
      .alloc_en  (alloc_en),
      .alloc_reg (alloc_reg),
      .busy_vec  (busy_vec)
   );

   // Free-running clock, period 10.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Builds one vector; read and expected-data arguments are given port 0 first.
   function automatic vec_t mk(
      input string n, input logic [1:0] we,
      input logic [4:0] wr0, input logic [31:0] wd0,
      input logic [4:0] wr1, input logic [31:0] wd1,
      input logic ae, input logic [4:0] ar,
      input logic [4:0] r0, input logic [4:0] r1,
      input logic [4:0] r2, input logic [4:0] r3,
      input logic [31:0] e0, input logic [31:0] e1,
      input logic [31:0] e2, input logic [31:0] e3,
      input logic [3:0] eb, input logic [31:0] ebv);
      vec_t v;
      v.name     = n;
      v.we       = we;
      v.wreg     = {wr1, wr0};
      v.wdata    = {wd1, wd0};
      v.ae       = ae;
      v.areg     = ar;
      v.rreg     = {r3, r2, r1, r0};
      v.exp_data = {e3, e2, e1, e0};
      v.exp_busy = eb;
      v.exp_bv   = ebv;
      return v;
   endfunction

   // Drives one vector on the falling edge and waits until just after the
   // next rising edge.
   task automatic applyStimulus(input vec_t v);
      @(negedge clk);
      wr_en     = v.we;
      wr_reg    = v.wreg;
      wr_data   = v.wdata;
      alloc_en  = v.ae;
      alloc_reg = v.areg;
      rd_reg    = v.rreg;
      @(posedge clk);
      #1;
   endtask

   // Compares every read port, the busy flags and the scoreboard.
   task automatic checkOutput(input string n, input logic [127:0] ed,
                              input logic [3:0] eb, input logic [31:0] ebv);
      for (int p = 0; p < RP; p++) begin
         checks++;
         if (rd_data[p*32 +: 32] !== ed[p*32 +: 32]) begin
            errors++;
            $display("[TB] FAIL %s rd_data[%0d]: got 0x%08h expected 0x%08h",
                     n, p, rd_data[p*32 +: 32], ed[p*32 +: 32]);
         end
      end
      checks++;
      if (rd_busy !== eb) begin
         errors++;
         $display("[TB] FAIL %s rd_busy: got %b expected %b", n, rd_busy, eb);
      end
      checks++;
      if (busy_vec !== ebv) begin
         errors++;
         $display("[TB] FAIL %s busy_vec: got 0x%08h expected 0x%08h", n, busy_vec, ebv);
      end
   endtask

   initial begin
      vec_t v;
      checks    = 0;
      errors    = 0;
      areset    = 1'b1;
      wr_en     = '0;
      wr_reg    = '0;
      wr_data   = '0;
      alloc_en  = 1'b0;
      alloc_reg = '0;
      rd_reg    = '0;

      //                name            we     wr0 wd0           wr1 wd1           ae    ar  rd0 rd1 rd2 rd3  exp0          exp1          exp2  exp3          busy     bv
      vecs[0]  = mk("wr_r5",         2'b01, 5,  32'h1234,     0,  32'h0,        1'b0, 0,  0,  0,  0,  0,   32'h0,        32'h0,        32'h0, 32'h0,        4'b0000, 32'h0);
      vecs[1]  = mk("r0_ignored",    2'b11, 0,  32'hDEADBEEF, 0,  32'hDEADBEEF, 1'b1, 0,  5,  5,  0,  0,   32'h1234,     32'h1234,     32'h0, 32'h0,        4'b0000, 32'h0);
      vecs[2]  = mk("conflict_wr",   2'b11, 3,  32'h11,       3,  32'h22,       1'b0, 0,  0,  0,  0,  0,   32'h0,        32'h0,        32'h0, 32'h0,        4'b0000, 32'h0);
      vecs[3]  = mk("alloc_r7",      2'b00, 0,  32'h0,        0,  32'h0,        1'b1, 7,  3,  3,  0,  5,   32'h22,       32'h22,       32'h0, 32'h1234,     4'b0000, 32'h80);
      vecs[4]  = mk("busy_read",     2'b11, 1,  32'hA,        2,  32'hB,        1'b0, 0,  7,  3,  0,  0,   32'h0,        32'h22,       32'h0, 32'h0,        4'b0001, 32'h80);
      vecs[5]  = mk("port_indep",    2'b00, 0,  32'h0,        0,  32'h0,        1'b0, 0,  1,  2,  1,  0,   32'hA,        32'hB,        32'hA, 32'h0,        4'b0000, 32'h80);
      vecs[6]  = mk("wb_clear",      2'b10, 7,  32'hBAD,      7,  32'h55,       1'b0, 0,  1,  2,  3,  5,   32'hA,        32'hB,        32'h22, 32'h1234,    4'b0000, 32'h0);
      vecs[7]  = mk("after_wb",      2'b00, 0,  32'h0,        0,  32'h0,        1'b0, 0,  7,  7,  7,  7,   32'h55,       32'h55,       32'h55, 32'h55,      4'b0000, 32'h0);
      vecs[8]  = mk("alloc_and_wr",  2'b01, 7,  32'h66,       0,  32'h0,        1'b1, 7,  0,  0,  0,  0,   32'h0,        32'h0,        32'h0, 32'h0,        4'b0000, 32'h80);
      vecs[9]  = mk("set_wins",      2'b00, 0,  32'h0,        0,  32'h0,        1'b0, 0,  7,  0,  0,  0,   32'h66,       32'h0,        32'h0, 32'h0,        4'b0001, 32'h80);
      vecs[10] = mk("realloc",       2'b00, 0,  32'h0,        0,  32'h0,        1'b1, 7,  7,  0,  0,  0,   32'h66,       32'h0,        32'h0, 32'h0,        4'b0001, 32'h80);
      vecs[11] = mk("wb_and_alloc",  2'b01, 7,  32'h77,       0,  32'h0,        1'b1, 12, 1,  0,  0,  0,   32'hA,        32'h0,        32'h0, 32'h0,        4'b0000, 32'h1000);
      vecs[12] = mk("after_wb2",     2'b00, 0,  32'h0,        0,  32'h0,        1'b0, 0,  7,  12, 0,  0,   32'h77,       32'h0,        32'h0, 32'h0,        4'b0010, 32'h1000);

      // Reset state while areset is held.
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_init", 128'h0, 4'b0000, 32'h0);
      @(negedge clk);
      areset = 1'b0;

      for (int i = 0; i < 13; i++) begin
         applyStimulus(vecs[i]);
         checkOutput(vecs[i].name, vecs[i].exp_data, vecs[i].exp_busy, vecs[i].exp_bv);
      end

      // Same-edge write and read of a busy register.
      v = mk("byp_setup", 2'b01, 9, 32'h1, 0, 32'h0, 1'b1, 9, 0, 0, 0, 0,
             32'h0, 32'h0, 32'h0, 32'h0, 4'b0000, 32'h1200);
      applyStimulus(v);
      checkOutput(v.name, v.exp_data, v.exp_busy, v.exp_bv);
`ifdef REGFILE_BYPASS_EN
      v = mk("byp_same_edge", 2'b01, 9, 32'h2, 0, 32'h0, 1'b0, 0, 9, 9, 0, 0,
             32'h2, 32'h2, 32'h0, 32'h0, 4'b0000, 32'h1000);
`else
      v = mk("byp_same_edge", 2'b01, 9, 32'h2, 0, 32'h0, 1'b0, 0, 9, 9, 0, 0,
             32'h1, 32'h1, 32'h0, 32'h0, 4'b0011, 32'h1000);
`endif
      applyStimulus(v);
      checkOutput(v.name, v.exp_data, v.exp_busy, v.exp_bv);
      v = mk("byp_next", 2'b00, 0, 32'h0, 0, 32'h0, 1'b0, 0, 9, 9, 0, 0,
             32'h2, 32'h2, 32'h0, 32'h0, 4'b0000, 32'h1000);
      applyStimulus(v);
      checkOutput(v.name, v.exp_data, v.exp_busy, v.exp_bv);

      // Mid-operation reset: outputs non-zero beforehand, zero immediately.
      v = mk("pre_reset", 2'b00, 0, 32'h0, 0, 32'h0, 1'b0, 0, 5, 12, 9, 5,
             32'h1234, 32'h0, 32'h2, 32'h1234, 4'b0010, 32'h1000);
      applyStimulus(v);
      checkOutput(v.name, v.exp_data, v.exp_busy, v.exp_bv);
      @(negedge clk);
      areset = 1'b1;
      #1;
      checkOutput("reset_async", 128'h0, 4'b0000, 32'h0);
      @(posedge clk);
      #1;
      checkOutput("reset_hold", 128'h0, 4'b0000, 32'h0);
      @(negedge clk);
      areset = 1'b0;
      v = mk("post_reset", 2'b00, 0, 32'h0, 0, 32'h0, 1'b0, 0, 5, 12, 9, 3,
             32'h0, 32'h0, 32'h0, 32'h0, 4'b0000, 32'h0);
      applyStimulus(v);
      checkOutput(v.name, v.exp_data, v.exp_busy, v.exp_bv);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
